// File: rtl/lbp_window_sched.sv
// lbp_window_sched: raster-scan frame scheduler for the LBP window engine.
// Border pixels are written as 0 directly; each interior pixel runs one datapath job.
module lbp_window_sched #(
    parameter int IMG_W   = 128,
    parameter int IMG_H   = 128,
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    output logic              eng_start,
    output logic [ADDR_W-1:0] eng_center,
    input  logic              eng_done,
    input  logic [7:0]        eng_lbp,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic              lbp_valid,
    output logic [7:0]        lbp_data,
    output logic              finish,
    output logic              err_timeout
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [XW-1:0]     COL_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     ROW_LAST = YW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(IMG_W * IMG_H - 1);
    // WAIT lasts at most TIMEOUT-1 cycles: expiry when the count is about to reach TIMEOUT-1
    localparam logic [CW-1:0]     CNT_EXP  = CW'(TIMEOUT - 2);

    typedef enum logic [2:0] {IDLE, BORDER, ISSUE, WAIT, WRITE, DONE} state_t;

    state_t            state, state_n;
    logic [XW-1:0]     col, col_n, col_nx;
    logic [YW-1:0]     row, row_n, row_nx;
    logic [ADDR_W-1:0] pix, pix_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [7:0]        cap, cap_n;
    logic              err, err_n;
    logic              col_wrap, next_border;

    assign col_wrap    = col == COL_LAST;
    assign col_nx      = col_wrap ? '0 : col + 1'b1;
    assign row_nx      = col_wrap ? row + 1'b1 : row;
    assign next_border = row_nx == '0 || row_nx == ROW_LAST || col_nx == '0 || col_nx == COL_LAST;

    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        pix_n   = pix;
        cnt_n   = cnt;
        cap_n   = cap;
        err_n   = err;
        case (state)
            IDLE: state_n = gray_ready ? BORDER : IDLE;
            ISSUE: if (gray_ready) begin
                state_n = WAIT;
                cnt_n   = '0;
            end
            WAIT: begin
                cnt_n = cnt + 1'b1;
                if (eng_done) begin
                    cap_n   = eng_lbp;
                    state_n = WRITE;
                end else if (cnt == CNT_EXP) begin
                    cap_n   = '0;
                    err_n   = 1'b1;
                    state_n = WRITE;
                end
            end
            BORDER, WRITE: if (pix == PIX_LAST) begin
                state_n = DONE;
            end else begin
                col_n   = col_nx;
                row_n   = row_nx;
                pix_n   = pix + 1'b1;
                state_n = next_border ? BORDER : ISSUE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
            pix   <= '0;
            cnt   <= '0;
            cap   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            col   <= col_n;
            row   <= row_n;
            pix   <= pix_n;
            cnt   <= cnt_n;
            cap   <= cap_n;
            err   <= err_n;
        end
    end

    assign eng_start   = state == ISSUE && gray_ready;
    assign eng_center  = pix;
    assign lbp_addr    = pix;
    assign lbp_valid   = state == BORDER || state == WRITE;
    assign lbp_data    = state == WRITE ? cap : '0;
    assign finish      = state == DONE;
    assign err_timeout = err;
endmodule

// File: tb/tb_lbp_window_sched.sv
// tb_lbp_window_sched: randomized engine model and per-frame write scoreboard for a 4x4 instance,
// plus a full-size 128x128 frame count on a second instance.
module tb_lbp_window_sched;
    localparam int W = 4, H = 4, N = 16, TO = 8;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, gray_ready, eng_done, eng_start, lbp_valid, finish, err_timeout;
    logic [7:0] eng_lbp, lbp_data;
    logic [3:0] eng_center, lbp_addr;

    lbp_window_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(4), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(rst_n), .gray_ready(gray_ready), .eng_start(eng_start),
        .eng_center(eng_center), .eng_done(eng_done), .eng_lbp(eng_lbp), .lbp_addr(lbp_addr),
        .lbp_valid(lbp_valid), .lbp_data(lbp_data), .finish(finish), .err_timeout(err_timeout)
    );

    logic        b_rst_n, b_gr, b_done, b_start, b_valid, b_finish, b_err;
    logic [7:0]  b_lbp, b_data;
    logic [13:0] b_center, b_addr;

    lbp_window_sched b_dut (
        .clk(clk), .reset(b_rst_n), .gray_ready(b_gr), .eng_start(b_start),
        .eng_center(b_center), .eng_done(b_done), .eng_lbp(b_lbp), .lbp_addr(b_addr),
        .lbp_valid(b_valid), .lbp_data(b_data), .finish(b_finish), .err_timeout(b_err)
    );

    int         n_cmp = 0, n_bad = 0;
    int         cyc, starts, wr_cnt, fin_cyc, err_cyc, done_at, job_c, silent, exact_c, dmin, dmax;
    bit         pending, in_job, spur, fixed, gr_next, gr_rand;
    logic [7:0] resp_val;
    logic [7:0] exp_val [N];
    logic [7:0] wr_data [N];
    int         wr_addr [N];
    int         wr_cyc  [N];
    int         start_cyc [N];
    int         interior [4] = '{5, 6, 9, 10};

    // Expected result for an address: border pixels are 0, interior carry whatever the engine returned
    function automatic logic [7:0] model(int a);
        int r, c;
        r = a / W;
        c = a % W;
        return (r == 0 || r == H - 1 || c == 0 || c == W - 1) ? 8'h00 : exp_val[a];
    endfunction

    task automatic step();
        logic due;
        int   c, d;
        @(posedge clk);
        cyc++;
        #1;
        due        = pending && cyc == done_at;
        if (gr_rand) gr_next = 1'($urandom_range(1, 0));
        gray_ready = gr_next;
        eng_done   = spur || due;
        eng_lbp    = due ? resp_val : 8'($urandom);
        if (due) pending = 0;
        spur = 0;
        @(negedge clk);
        if (in_job) begin
            n_cmp++;
            if (eng_center !== 4'(job_c)) begin
                n_bad++;
                $display("FAIL center_stable cyc %0d: eng_center %0d, expected %0d", cyc, eng_center, job_c);
            end
            if (due || lbp_valid) in_job = 0;
        end
        if (eng_start) begin
            n_cmp++;
            if (gray_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL start_needs_ready cyc %0d: eng_start with gray_ready %b", cyc, gray_ready);
            end
            starts++;
            c = int'(eng_center);
            start_cyc[c] = cyc;
            job_c  = c;
            in_job = 1;
            if (c != silent) begin
                d        = (c == exact_c) ? TO - 1 : int'($urandom_range(dmax, dmin));
                resp_val = fixed ? 8'hA0 + 8'(c) : 8'($urandom);
                exp_val[c] = resp_val;
                pending  = 1;
                done_at  = cyc + d;
            end
        end
        if (lbp_valid) begin
            if (wr_cnt < N) begin
                wr_addr[wr_cnt] = int'(lbp_addr);
                wr_data[wr_cnt] = lbp_data;
            end
            wr_cyc[lbp_addr] = cyc;
            wr_cnt++;
        end
        if (err_timeout && err_cyc < 0) err_cyc = cyc;
        if (finish && fin_cyc < 0) fin_cyc = cyc;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        {gr_next, gr_rand, gray_ready, eng_done, pending, in_job, spur, fixed} = '0;
        eng_lbp = '0;
        for (int i = 0; i < N; i++) begin
            exp_val[i] = 8'h00; wr_data[i] = 'x; wr_addr[i] = -1; wr_cyc[i] = -1; start_cyc[i] = -1;
        end
        {starts, wr_cnt} = '0;
        {fin_cyc, err_cyc, silent, exact_c} = {-1, -1, -1, -1};
        dmin = 1;
        dmax = 6;
        repeat (2) step();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic run_frame();
        for (int i = 0; i < 400 && fin_cyc < 0; i++) step();
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({eng_start, eng_center, lbp_addr, lbp_valid, lbp_data, finish, err_timeout} !== 20'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, expected 0",
                {eng_start, eng_center, lbp_addr, lbp_valid, lbp_data, finish, err_timeout});
        end
        do_reset();
        repeat (5) step();
        n_cmp++;
        if (wr_cnt != 0 || starts != 0 || finish !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_without_ready: writes %0d starts %0d finish %b, expected 0 0 0", wr_cnt, starts, finish);
        end
    endtask

    task automatic test_frame();
        do_reset();
        fixed = 1; dmin = 3; dmax = 3; gr_next = 1;
        run_frame();
        n_cmp++;
        if (wr_cnt != N || starts != 4) begin
            n_bad++;
            $display("FAIL frame_counts: writes %0d starts %0d, expected %0d 4", wr_cnt, starts, N);
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (wr_addr[i] != i || wr_data[i] !== model(i)) begin
                n_bad++;
                $display("FAIL frame_write %0d: addr %0d data %h, expected addr %0d data %h", i, wr_addr[i], wr_data[i], i, model(i));
            end
        end
        n_cmp++;
        if (wr_data[5] !== 8'hA5 || wr_data[10] !== 8'hAA) begin
            n_bad++;
            $display("FAIL frame_values: addr5 %h addr10 %h, expected A5 AA", wr_data[5], wr_data[10]);
        end
        foreach (interior[k]) begin
            n_cmp++;
            if (wr_cyc[interior[k]] - start_cyc[interior[k]] != 4) begin
                n_bad++;
                $display("FAIL frame_latency c%0d: start %0d write %0d, expected write 4 cycles after start",
                    interior[k], start_cyc[interior[k]], wr_cyc[interior[k]]);
            end
        end
        n_cmp++;
        if (wr_cyc[4] - wr_cyc[0] != 4 || fin_cyc != wr_cyc[15] + 1 || err_timeout !== 1'b0 || finish !== 1'b1) begin
            n_bad++;
            $display("FAIL frame_timing: border span %0d fin %0d last write %0d err %b finish %b, expected 4 %0d - 0 1",
                wr_cyc[4] - wr_cyc[0], fin_cyc, wr_cyc[15], wr_cyc[15] + 1, err_timeout, finish);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        silent = 6; gr_next = 1;
        run_frame();
        n_cmp++;
        if (wr_cyc[6] - start_cyc[6] != TO || wr_data[6] !== 8'h00) begin
            n_bad++;
            $display("FAIL timeout_write: delay %0d data %h, expected %0d 00", wr_cyc[6] - start_cyc[6], wr_data[6], TO);
        end
        n_cmp++;
        if (err_cyc != wr_cyc[6] || err_timeout !== 1'b1 || finish !== 1'b1 || wr_cnt != N) begin
            n_bad++;
            $display("FAIL timeout_err: err rise %0d err %b finish %b writes %0d, expected %0d 1 1 %0d",
                err_cyc, err_timeout, finish, wr_cnt, wr_cyc[6], N);
        end
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (wr_addr[i] != i || wr_data[i] !== model(i)) begin
                n_bad++;
                $display("FAIL timeout_frame %0d: addr %0d data %h, expected addr %0d data %h", i, wr_addr[i], wr_data[i], i, model(i));
            end
        end
    endtask

    task automatic test_expiry_race();
        do_reset();
        exact_c = interior[$urandom_range(3, 0)]; gr_next = 1;
        run_frame();
        n_cmp++;
        if (wr_cyc[exact_c] - start_cyc[exact_c] != TO || wr_data[exact_c] !== exp_val[exact_c]
            || err_timeout !== 1'b0 || err_cyc != -1) begin
            n_bad++;
            $display("FAIL expiry_race c%0d: delay %0d data %h err %b, expected %0d %h 0",
                exact_c, wr_cyc[exact_c] - start_cyc[exact_c], wr_data[exact_c], err_timeout, TO, exp_val[exact_c]);
        end
    endtask

    task automatic test_gray_ready();
        int rel;
        do_reset();
        repeat (9) step();
        n_cmp++;
        if (wr_cnt != 0 || starts != 0) begin
            n_bad++;
            $display("FAIL ready_quiet: writes %0d starts %0d, expected 0 0", wr_cnt, starts);
        end
        gr_next = 1;
        for (int i = 0; i < 50 && wr_cnt < 3; i++) step();
        gr_next = 0;
        repeat (6) step();
        n_cmp++;
        if (wr_cnt != 5 || starts != 0 || wr_cyc[0] != 11 || wr_cyc[4] - wr_cyc[0] != 4) begin
            n_bad++;
            $display("FAIL ready_stall: writes %0d starts %0d first %0d span %0d, expected 5 0 11 4",
                wr_cnt, starts, wr_cyc[0], wr_cyc[4] - wr_cyc[0]);
        end
        gr_next = 1;
        rel = cyc + 1;
        run_frame();
        n_cmp++;
        if (start_cyc[5] != rel || wr_cnt != N || finish !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_resume: start5 %0d writes %0d finish %b, expected %0d %0d 1", start_cyc[5], wr_cnt, finish, rel, N);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        silent = 9; gr_next = 1;
        for (int i = 0; i < 200 && !(start_cyc[9] >= 0 && cyc >= start_cyc[9] + 2); i++) step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({eng_start, eng_center, lbp_addr, lbp_valid, lbp_data, finish, err_timeout} !== 20'd0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %h, expected 0",
                {eng_start, eng_center, lbp_addr, lbp_valid, lbp_data, finish, err_timeout});
        end
        do_reset();
        spur = 1;
        repeat (3) step();
        n_cmp++;
        if (wr_cnt != 0 || starts != 0 || err_cyc != -1 || lbp_data !== 8'h00) begin
            n_bad++;
            $display("FAIL spurious_done: writes %0d starts %0d err rise %0d data %h, expected 0 0 -1 00",
                wr_cnt, starts, err_cyc, lbp_data);
        end
        gr_next = 1;
        run_frame();
        for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (wr_addr[i] != i || wr_data[i] !== model(i)) begin
                n_bad++;
                $display("FAIL rerun_write %0d: addr %0d data %h, expected addr %0d data %h", i, wr_addr[i], wr_data[i], i, model(i));
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            do_reset();
            gr_rand = 1; dmax = 7;
            silent = $urandom_range(1, 0) == 1 ? interior[$urandom_range(3, 0)] : -1;
            run_frame();
            n_cmp++;
            if (wr_cnt != N || finish !== 1'b1 || err_timeout !== (silent >= 0)) begin
                n_bad++;
                $display("FAIL random%0d_status: writes %0d finish %b err %b, expected %0d 1 %b",
                    f, wr_cnt, finish, err_timeout, N, silent >= 0);
            end
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (wr_addr[i] != i || wr_data[i] !== model(i)) begin
                    n_bad++;
                    $display("FAIL random%0d_write %0d: addr %0d data %h, expected addr %0d data %h",
                        f, i, wr_addr[i], wr_data[i], i, model(i));
                end
            end
        end
    endtask

    task automatic test_full_size();
        int nv = 0, ns = 0, bad_order = 0, last_wr = -1, fin = -1, c = 0;
        bit due = 0;
        b_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        b_rst_n = 1'b1;
        b_gr    = 1'b1;
        while (fin < 0 && c < 60000) begin
            @(posedge clk);
            c++;
            #1;
            b_done = due;
            b_lbp  = 8'($urandom);
            due    = 0;
            @(negedge clk);
            if (b_start) begin ns++; due = 1; end
            if (b_valid) begin
                if (b_addr !== 14'(nv)) bad_order++;
                nv++;
                last_wr = c;
            end
            if (b_finish) fin = c;
        end
        n_cmp++;
        if (nv != 16384 || ns != 15876 || bad_order != 0) begin
            n_bad++;
            $display("FAIL full_counts: writes %0d starts %0d out-of-order %0d, expected 16384 15876 0", nv, ns, bad_order);
        end
        n_cmp++;
        if (fin != last_wr + 1) begin
            n_bad++;
            $display("FAIL full_finish: finish cycle %0d, expected %0d", fin, last_wr + 1);
        end
    endtask

    initial begin
        rst_n = 1'b0; gr_next = 0; gray_ready = 0; eng_done = 0; eng_lbp = '0; cyc = 0;
        b_rst_n = 1'b0; b_gr = 1'b0; b_done = 1'b0; b_lbp = '0;
        test_reset();
        test_frame();
        test_timeout();
        test_expiry_race();
        test_gray_ready();
        test_mid_reset();
        test_random();
        test_full_size();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
